pass_lock: RTL
==============

# pass_lock

Parametrised successor to the single-channel pass shifter: a serial code-entry lock that samples one bit of `in` per divided tick, shows the entry on `LED`, and compares the completed entry against a programmable code. A match asserts `out` for a timed window. A mismatch consumes one attempt and can trigger a lockout period. It sits between the board switch/button debouncers and the door/status logic, in the same slot as the existing pass block.

## Interface
- `CODE_LEN`, 8: entry/code width in bits, 1..32.
- `TICK_DIV`, 50_000_000: clk cycles per sample tick (500 ms at 100 MHz), >=2.
- `OPEN_TICKS`, 6: ticks `out` stays high after a match, >=1.
- `MAX_TRIES`, 3: consecutive failures allowed before lockout, 1..15.
- `LOCK_TICKS`, 20: lockout duration in ticks, >=1.

- `clk`: in, 1, sole clock.
- `reset_local`: in, 1, asynchronous active-high reset.
- `reset_pass`: in, 1, synchronous clear of the entry in progress.
- `in`: in, 1, serial code bit, already debounced and synchronised.
- `code`: in, `CODE_LEN`, target code, sampled in CHECK.
- `passreset`: out, 1, one-cycle pulse whenever the entry register is cleared.
- `out`: out, 1, high while OPEN.
- `LED`: out, `CODE_LEN`, live entry register; all ones in LOCKOUT.
- `locked`: out, 1, high while LOCKOUT.
- `tries_left`: out, 4, remaining attempts.

## Operation
- States: IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT.
- Tick: one-cycle pulse when the free-running divider reaches `TICK_DIV-1`. The divider then wraps to 0. It is cleared only by `reset_local`.
- Shifting:
  - A tick in IDLE or ENTRY shifts `in` into bit 0 and moves the register left; the first bit ends at the MSB.
  - The bit count increments with each shift.
  - IDLE moves to ENTRY on the first shift.
  - When the count reaches `CODE_LEN`, the FSM goes to CHECK on the next cycle.
- CHECK (1 cycle):
  - Entry == `code` → OPEN; `tries_left` reloads to `MAX_TRIES`.
  - Otherwise → FAIL.
- OPEN:
  - `out`=1 for `OPEN_TICKS` ticks, counting ticks after entry.
  - On the final tick it goes to IDLE: the register and count are cleared and `passreset` pulses.
- FAIL (1 cycle):
  - `tries_left` decrements.
  - If the result is 0 → LOCKOUT. Otherwise → IDLE with the register cleared and a `passreset` pulse.
- LOCKOUT:
  - `locked`=1, `LED`=all ones, `in` ignored.
  - After `LOCK_TICKS` ticks it goes to IDLE: `tries_left` reloads, the register is cleared and `passreset` pulses.
- `reset_pass` in IDLE, ENTRY, CHECK or OPEN:
  - Clears the register and count, drops `out`, forces IDLE and pulses `passreset` on the next cycle.
  - It does not change `tries_left`.
- `reset_pass` is ignored in FAIL and LOCKOUT.
- Simultaneous `reset_pass` and tick: `reset_pass` wins and the sampled bit is discarded.

## Timing
- Reset values: state IDLE, `out`=0, `locked`=0, `passreset`=0, `LED`=0, `tries_left`=`MAX_TRIES`, divider=0.
- Latency: `LED` updates the cycle after a tick. A full entry reaches CHECK 1 cycle after the `CODE_LEN`-th tick. `out` rises 2 cycles after that tick.
- `passreset`: exactly one cycle, registered, high the cycle the cleared register first appears.
- `reset_local` mid-entry, mid-OPEN or mid-LOCKOUT: immediate return to the reset values, with no `passreset` pulse.
- All outputs are registered.

## Configuration
- `PASS_LOCKOUT_EN`:
  - Defined: FAIL/LOCKOUT behaviour as specified above.
  - Undefined: FAIL always returns to IDLE and LOCKOUT is unreachable. `locked` is tied to 0 and `tries_left` is tied to `MAX_TRIES`. The try and lock counters are not synthesised.

## Structure
- `pass_pkg`: state enum, `TRIES_W`=4, and an elaboration-time parameter range check function.
- Sub-module `pass_tick`: tick divider, parameter `TICK_DIV`, ports `clk`, `reset_local` and `tick`.
- Remaining FSM and datapath in `pass_lock`.

## Test plan
Bench parameters: `TICK_DIV`=4, `CODE_LEN`=4, `OPEN_TICKS`=2, `MAX_TRIES`=2, `LOCK_TICKS`=3, `code`=4'b1011, `PASS_LOCKOUT_EN` defined.

- Correct entry: shift 1,0,1,1 → `LED` 0001, 0010, 0101, 1011; `out`=1 for 8 cycles, then `passreset` pulse and `LED`=0.
- Wrong entry: shift 1,1,1,1 → `tries_left` 2→1, `passreset` pulse, `out` stays 0.
- Two wrong entries: `locked`=1 and `LED`=1111 for 12 cycles with `in` toggling; then `tries_left`=2 and `passreset` pulses.
- `reset_pass` after 2 bits, coincident with a tick → that bit is dropped, `LED`=0, one `passreset` pulse, `tries_left` unchanged.
- `reset_local` during OPEN → `out`=0 immediately, no `passreset`, next 4 bits form a fresh entry.
- `PASS_LOCKOUT_EN` undefined: three wrong entries → `locked` always 0, `tries_left` stays 2.

Source files
------------

// File: rtl/pass_pkg.sv
// pass_pkg: state encoding, tries width and parameter range check shared by pass_lock.
package pass_pkg;
    localparam int TRIES_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_FAIL,
        S_LOCKOUT
    } state_t;

    function automatic bit params_ok(input int code_len, input int tick_div, input int open_ticks,
                                     input int max_tries, input int lock_ticks);
        return code_len >= 1 && code_len <= 32 && tick_div >= 2 && open_ticks >= 1 &&
               max_tries >= 1 && max_tries <= 15 && lock_ticks >= 1;
    endfunction
endpackage

// File: rtl/pass_tick.sv
// pass_tick: free-running divider giving a one-cycle tick every TICK_DIV clocks.
module pass_tick #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset_local,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] r_cnt;

    assign tick = r_cnt == W'(TICK_DIV - 1);

    always_ff @(posedge clk or posedge reset_local)
        if (reset_local) r_cnt <= '0;
        else r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/pass_lock.sv
// pass_lock: serial code-entry lock with a timed open window.
// Define PASS_LOCKOUT_EN to add the try counter and the LOCKOUT period.
module pass_lock
    import pass_pkg::*;
#(
    parameter int CODE_LEN   = 8,
    parameter int TICK_DIV   = 50_000_000,
    parameter int OPEN_TICKS = 6,
    parameter int MAX_TRIES  = 3,
    parameter int LOCK_TICKS = 20
) (
    input  logic                clk,
    input  logic                reset_local,
    input  logic                reset_pass,
    input  logic                in,
    input  logic [CODE_LEN-1:0] code,
    output logic                passreset,
    output logic                out,
    output logic [CODE_LEN-1:0] LED,
    output logic                locked,
    output logic [TRIES_W-1:0]  tries_left
);
    localparam int BW = $clog2(CODE_LEN + 1);
`ifdef PASS_LOCKOUT_EN
    localparam int TMAX = OPEN_TICKS > LOCK_TICKS ? OPEN_TICKS : LOCK_TICKS;
`else
    localparam int TMAX = OPEN_TICKS;
`endif
    localparam int TW = $clog2(TMAX + 1);

    if (!params_ok(CODE_LEN, TICK_DIV, OPEN_TICKS, MAX_TRIES, LOCK_TICKS)) begin : g_bad_params
        $error("pass_lock: parameter out of range");
    end

    state_t              r_state;
    logic [BW-1:0]       r_bits;
    logic [TW-1:0]       r_tcnt;
    logic [CODE_LEN-1:0] r_led;
    logic                r_out;
    logic                r_pr;
    logic                w_tick;
    logic                w_match;
    logic                w_open_done;
    logic                w_lock_done;
    logic                w_to_lock;
    logic                w_clear;

    pass_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk        (clk),
        .reset_local(reset_local),
        .tick       (w_tick)
    );

    assign w_match     = r_led == code;
    assign w_open_done = r_state == S_OPEN && w_tick && r_tcnt == TW'(OPEN_TICKS - 1);
    // Every path back to IDLE funnels through w_clear so passreset cannot be missed.
    assign w_clear     = (reset_pass && r_state inside {S_IDLE, S_ENTRY, S_CHECK, S_OPEN}) ||
                         w_open_done || w_lock_done || (r_state == S_FAIL && !w_to_lock);

`ifdef PASS_LOCKOUT_EN
    logic [TRIES_W-1:0] r_tries;
    logic               r_locked;

    assign w_to_lock   = r_state == S_FAIL && r_tries == TRIES_W'(1);
    assign w_lock_done = r_state == S_LOCKOUT && w_tick && r_tcnt == TW'(LOCK_TICKS - 1);
    assign locked      = r_locked;
    assign tries_left  = r_tries;

    always_ff @(posedge clk or posedge reset_local)
        if (reset_local) begin
            r_tries  <= TRIES_W'(MAX_TRIES);
            r_locked <= 1'b0;
        end else begin
            if ((r_state == S_CHECK && !reset_pass && w_match) || w_lock_done) r_tries <= TRIES_W'(MAX_TRIES);
            else if (r_state == S_FAIL) r_tries <= r_tries - 1'b1;
            r_locked <= w_to_lock || (r_locked && !w_lock_done);
        end
`else
    assign w_to_lock   = 1'b0;
    assign w_lock_done = 1'b0;
    assign locked      = 1'b0;
    assign tries_left  = TRIES_W'(MAX_TRIES);
`endif

    always_ff @(posedge clk or posedge reset_local)
        if (reset_local) begin
            r_state <= S_IDLE;
            r_bits  <= '0;
            r_tcnt  <= '0;
            r_led   <= '0;
            r_out   <= 1'b0;
            r_pr    <= 1'b0;
        end else if (w_clear) begin
            r_state <= S_IDLE;
            r_bits  <= '0;
            r_led   <= '0;
            r_out   <= 1'b0;
            r_pr    <= 1'b1;
        end else begin
            r_pr <= 1'b0;
            case (r_state)
                S_IDLE, S_ENTRY: if (w_tick) begin
                    r_led   <= (r_led << 1) | CODE_LEN'(in);
                    r_bits  <= r_bits + 1'b1;
                    r_state <= r_bits == BW'(CODE_LEN - 1) ? S_CHECK : S_ENTRY;
                end
                S_CHECK: begin
                    r_state <= w_match ? S_OPEN : S_FAIL;
                    r_out   <= w_match;
                    r_tcnt  <= '0;
                end
                S_OPEN: if (w_tick) r_tcnt <= r_tcnt + 1'b1;
`ifdef PASS_LOCKOUT_EN
                S_FAIL: begin
                    r_state <= S_LOCKOUT;
                    r_led   <= '1;
                    r_tcnt  <= '0;
                end
                S_LOCKOUT: if (w_tick) r_tcnt <= r_tcnt + 1'b1;
`endif
                default: r_state <= S_IDLE;
            endcase
        end

    assign passreset = r_pr;
    assign out       = r_out;
    assign LED       = r_led;
endmodule
